// File: rtl/prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_arbiter
// Purpose  : Shares the single-ported program ROM between CPU instruction
//            fetch and the LPM (load-program-memory) byte-read path. At most
//            one access is accepted per cycle. The ROM address is registered,
//            and the word or byte comes back two cycles after acceptance.
// Ports    : clk, reset (async, active high)
//            fetch_req/fetch_addr -> fetch_gnt (comb), fetch_valid/fetch_data
//            lpm_req/lpm_addr     -> lpm_gnt (comb),   lpm_valid/lpm_data
//            rom_addr (registered) -> ROM, rom_data <- ROM
// Config   : PROG_MEM_FAIRNESS_EN defined means LPM may win at most
//            MAX_LPM_BURST consecutive grants while fetch waits. When it is
//            undefined, LPM has strict priority.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int MAX_LPM_BURST = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  lpm_req,
  input  logic [ADDR_WIDTH:0]   lpm_addr,
  output logic                  lpm_gnt,
  output logic                  lpm_valid,
  output logic [7:0]            lpm_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  // Stage occupancy encoding, shared by the owner and return stages
  localparam logic [1:0] c_ST_EMPTY = 2'd0;
  localparam logic [1:0] c_ST_FETCH = 2'd1;
  localparam logic [1:0] c_ST_LPM   = 2'd2;

  logic [1:0]            r_own_state;
  logic [1:0]            w_own_next;
  logic                  r_own_bsel;
  logic [1:0]            r_ret_state;
  logic [1:0]            w_ret_next;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic [7:0]            r_lpm_data;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef PROG_MEM_FAIRNESS_EN
  localparam int c_BURST_W = (MAX_LPM_BURST < 1) ? 1 : $clog2(MAX_LPM_BURST + 1);
  localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_LPM_BURST);

  logic [c_BURST_W-1:0] r_burst_cnt;
  logic                 w_force_fetch;

  // Once LPM has used its burst allowance, a waiting fetch takes this slot.
  assign w_force_fetch = fetch_req & (r_burst_cnt == c_MAX_BURST);
  assign lpm_gnt       = ~reset & lpm_req & ~w_force_fetch;

  // The count only measures LPM wins that happen while fetch is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (fetch_gnt || !fetch_req) begin
      r_burst_cnt <= '0;
    end else if (lpm_gnt) begin
      r_burst_cnt <= r_burst_cnt + c_BURST_W'(1);
    end
  end
`else
  assign lpm_gnt = ~reset & lpm_req;
`endif

  assign fetch_gnt = ~reset & fetch_req & ~lpm_gnt;

  // --------------------------------------------------------------------------
  // Pipeline state: state register / next-state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_own_state <= c_ST_EMPTY;
      r_ret_state <= c_ST_EMPTY;
    end else begin
      r_own_state <= w_own_next;
      r_ret_state <= w_ret_next;
    end
  end

  always_comb begin
    w_own_next = c_ST_EMPTY;
    if (lpm_gnt) begin
      w_own_next = c_ST_LPM;
    end else if (fetch_gnt) begin
      w_own_next = c_ST_FETCH;
    end
    // The return stage is always one step behind the owner stage.
    w_ret_next = r_own_state;
  end

  always_comb begin
    fetch_valid = (r_ret_state == c_ST_FETCH);
    lpm_valid   = (r_ret_state == c_ST_LPM);
  end

  // --------------------------------------------------------------------------
  // Address and data path
  // --------------------------------------------------------------------------
  // The address holds when nothing is accepted, so an idle ROM sees no change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
      r_own_bsel <= 1'b0;
    end else if (lpm_gnt) begin
      r_rom_addr <= lpm_addr[ADDR_WIDTH:1];
      r_own_bsel <= lpm_addr[0];
    end else if (fetch_gnt) begin
      r_rom_addr <= fetch_addr;
      r_own_bsel <= 1'b0;
    end
  end

  // rom_data matches the owner-stage address at this edge. It is captured
  // here, and the data registers hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_data <= '0;
      r_lpm_data   <= '0;
    end else if (r_own_state == c_ST_FETCH) begin
      r_fetch_data <= rom_data;
    end else if (r_own_state == c_ST_LPM) begin
      r_lpm_data <= r_own_bsel ? rom_data[15:8] : rom_data[7:0];
    end
  end

  assign rom_addr   = r_rom_addr;
  assign fetch_data = r_fetch_data;
  assign lpm_data   = r_lpm_data;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem_arbiter
// Purpose  : Self-checking bench for prog_mem_arbiter. It uses a ROM model
//            that is read on the falling edge, and a queue-based reference
//            model of returns (expected data, due cycle). The scenario tasks
//            below are directed and randomized.
// Config   : Define PROG_MEM_FAIRNESS_EN here and in the DUT to run the
//            fair-collision scenario in place of the strict one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mem_arbiter;

  localparam int c_DW   = 16;
  localparam int c_AW   = 8;
  localparam int c_MAXB = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             fetch_req = 1'b0;
  logic [c_AW-1:0]  fetch_addr = '0;
  logic             fetch_gnt;
  logic             fetch_valid;
  logic [c_DW-1:0]  fetch_data;
  logic             lpm_req = 1'b0;
  logic [c_AW:0]    lpm_addr = '0;
  logic             lpm_gnt;
  logic             lpm_valid;
  logic [7:0]       lpm_data;
  logic [c_AW-1:0]  rom_addr;
  logic [c_DW-1:0]  rom_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  prog_mem_arbiter #(
    .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .MAX_LPM_BURST(c_MAXB)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .lpm_req(lpm_req), .lpm_addr(lpm_addr), .lpm_gnt(lpm_gnt),
    .lpm_valid(lpm_valid), .lpm_data(lpm_data),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // ROM: it captures the address on the falling edge, so the data is ready
  // by the next rising edge.
  logic [c_DW-1:0] rom [0:255];
  always @(negedge clk) rom_data <= rom[rom_addr];

  // --------------------------------------------------------------------------
  // Reference model: a list of expected returns, each tagged with the cycle
  // in which it must appear (acceptance cycle + 2).
  // --------------------------------------------------------------------------
  typedef struct {
    int         due;
    bit         is_lpm;
    logic [15:0] fdata;
    logic [7:0]  ldata;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   burst = 0;

  function automatic bit m_lpm_wins(bit fr, bit lr, int b);
`ifdef PROG_MEM_FAIRNESS_EN
    return lr && !(fr && b >= c_MAXB);
`else
    return lr;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin : model
    exp_t e;
    bit   lg;
    bit   fg;
    if (reset) begin
      q.delete();
      burst = 0;
    end else begin
      lg = m_lpm_wins(fetch_req, lpm_req, burst);
      fg = fetch_req && !lg;
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      cyc++;
      if (lg || fg) begin
        e.due    = cyc + 1;
        e.is_lpm = lg;
        e.fdata  = rom[fetch_addr];
        e.ldata  = lpm_addr[0] ? rom[lpm_addr[c_AW:1]][15:8] : rom[lpm_addr[c_AW:1]][7:0];
        q.push_back(e);
      end
      if (fg || !fetch_req) burst = 0;
      else if (lg) burst++;
    end
  end

  task automatic idle(int n);
    fetch_req = 1'b0;
    lpm_req   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    fetch_req = 1'b1;
    lpm_req   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({fetch_gnt, lpm_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {fetch_gnt, lpm_gnt}); else n_pass++;
    n_checks++; if ({fetch_valid, lpm_valid} !== 2'b00) $display("FAIL reset_valid: got %b want 00", {fetch_valid, lpm_valid}); else n_pass++;
    n_checks++; if (rom_addr !== 8'h00) $display("FAIL reset_rom_addr: got %h want 00", rom_addr); else n_pass++;
    n_checks++; if (fetch_data !== 16'h0000 || lpm_data !== 8'h00) $display("FAIL reset_data: got %h/%h want 0000/00", fetch_data, lpm_data); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single_fetch;
    fetch_req  = 1'b1;
    fetch_addr = 8'h05;
    @(negedge clk);
    n_checks++; if (fetch_gnt !== 1'b1) $display("FAIL single_gnt: got %b want 1", fetch_gnt); else n_pass++;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    n_checks++; if (rom_addr !== 8'h05) $display("FAIL single_rom_addr: got %h want 05", rom_addr); else n_pass++;
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", fetch_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 16'hBB05) $display("FAIL single_return: valid %b data %h want 1 BB05", fetch_valid, fetch_data); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (fetch_valid !== 1'b0 || fetch_data !== 16'hBB05) $display("FAIL single_hold: valid %b data %h want 0 BB05", fetch_valid, fetch_data); else n_pass++;
    idle(2);
  endtask

  task automatic test_lpm_bytes;
    lpm_req  = 1'b1;
    lpm_addr = 9'h013;
    @(negedge clk);
    n_checks++; if (lpm_gnt !== 1'b1) $display("FAIL lpm_gnt: got %b want 1", lpm_gnt); else n_pass++;
    @(posedge clk); #1;
    lpm_addr = 9'h012;
    @(posedge clk); #1;
    lpm_req = 1'b0;
    @(negedge clk);
    n_checks++; if (lpm_valid !== 1'b1 || lpm_data !== 8'hBB) $display("FAIL lpm_hi: valid %b data %h want 1 BB", lpm_valid, lpm_data); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (lpm_valid !== 1'b1 || lpm_data !== 8'h06) $display("FAIL lpm_lo: valid %b data %h want 1 06", lpm_valid, lpm_data); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (lpm_valid !== 1'b0) $display("FAIL lpm_end: valid %b want 0", lpm_valid); else n_pass++;
    idle(2);
  endtask

`ifdef PROG_MEM_FAIRNESS_EN
  task automatic test_collision_fair;
    bit        pat [0:5];
    bit        seen [0:5];
    logic [15:0] w;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};  // 1 = LPM grant
    w = rom[8'h20];
    fetch_req = 1'b1; fetch_addr = 8'h21;
    lpm_req   = 1'b1; lpm_addr   = 9'h041;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin fetch_req = 1'b0; lpm_req = 1'b0; end
      @(negedge clk);
      if (i < 6) begin
        n_checks++; if ({fetch_gnt, lpm_gnt} !== {~pat[i], pat[i]}) $display("FAIL fair_gnt[%0d]: got %b want %b", i, {fetch_gnt, lpm_gnt}, {~pat[i], pat[i]}); else n_pass++;
      end
      if (i >= 2) begin
        seen[i-2] = lpm_valid;
        n_checks++;
        if (pat[i-2] ? (lpm_valid !== 1'b1 || lpm_data !== w[15:8]) : (fetch_valid !== 1'b1 || fetch_data !== rom[8'h21]))
          $display("FAIL fair_ret[%0d]: fv %b fd %h lv %b ld %h", i - 2, fetch_valid, fetch_data, lpm_valid, lpm_data);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    idle(2);
  endtask
`else
  task automatic test_collision_strict;
    int ng_l = 0;
    int ng_f = 0;
    fetch_req = 1'b1; fetch_addr = 8'h21;
    lpm_req   = 1'b1; lpm_addr   = 9'h041;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ng_l += int'(lpm_gnt);
      ng_f += int'(fetch_gnt);
      @(posedge clk); #1;
    end
    n_checks++; if (ng_l != 4 || ng_f != 0) $display("FAIL strict_counts: lpm %0d fetch %0d want 4 0", ng_l, ng_f); else n_pass++;
    lpm_req = 1'b0;
    @(negedge clk);
    n_checks++; if (fetch_gnt !== 1'b1) $display("FAIL strict_release: fetch_gnt %b want 1", fetch_gnt); else n_pass++;
    idle(3);
  endtask
`endif

  task automatic test_streaming;
    for (int i = 0; i < 13; i++) begin
      fetch_req  = (i < 10);
      fetch_addr = 8'(i);
      @(negedge clk);
      if (i >= 2 && i < 12) begin
        n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== rom[i-2]) $display("FAIL stream[%0d]: valid %b data %h want 1 %h", i - 2, fetch_valid, fetch_data, rom[i-2]); else n_pass++;
      end else if (i == 12) begin
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL stream_end: valid %b want 0", fetch_valid); else n_pass++;
      end
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  task automatic test_reset_midflight;
    fetch_req  = 1'b1;
    fetch_addr = 8'h07;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    n_checks++; if (rom_addr !== 8'h07) $display("FAIL mid_pre_addr: got %h want 07", rom_addr); else n_pass++;
    reset = 1'b1;
    fetch_req = 1'b1;
    lpm_req   = 1'b1;
    #1;
    n_checks++; if (rom_addr !== 8'h00 || fetch_data !== 16'h0000 || lpm_data !== 8'h00) $display("FAIL mid_async_zero: addr %h fd %h ld %h want 0", rom_addr, fetch_data, lpm_data); else n_pass++;
    n_checks++; if ({fetch_gnt, lpm_gnt, fetch_valid, lpm_valid} !== 4'b0000) $display("FAIL mid_async_ctl: got %b want 0000", {fetch_gnt, lpm_gnt, fetch_valid, lpm_valid}); else n_pass++;
    fetch_req = 1'b0;
    lpm_req   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL mid_no_valid[%0d]: got %b want 0", i, fetch_valid); else n_pass++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 8'h05;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(negedge clk);
    n_checks++; if (fetch_valid !== 1'b0) $display("FAIL mid_after_early: valid %b want 0", fetch_valid); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (fetch_valid !== 1'b1 || fetch_data !== 16'hBB05) $display("FAIL mid_after_return: valid %b data %h want 1 BB05", fetch_valid, fetch_data); else n_pass++;
    idle(2);
  endtask

  task automatic test_random(int ncyc);
    bit f_busy = 1'b0;
    bit l_busy = 1'b0;
    bit exp_lg;
    bit exp_fg;
    bit ev_f;
    bit ev_l;
    for (int i = 0; i < ncyc; i++) begin
      if (!f_busy) begin
        fetch_req  = ($urandom_range(0, 99) < 60);
        fetch_addr = 8'($urandom);
      end
      if (!l_busy) begin
        lpm_req  = ($urandom_range(0, 99) < 50);
        lpm_addr = 9'($urandom);
      end
      @(negedge clk);
      exp_lg = m_lpm_wins(fetch_req, lpm_req, burst);
      exp_fg = fetch_req && !exp_lg;
      ev_f   = (q.size() > 0) && (q[0].due == cyc) && !q[0].is_lpm;
      ev_l   = (q.size() > 0) && (q[0].due == cyc) && q[0].is_lpm;
      n_checks++; if ({fetch_gnt, lpm_gnt} !== {exp_fg, exp_lg}) $display("FAIL rand_gnt[%0d]: got %b want %b", i, {fetch_gnt, lpm_gnt}, {exp_fg, exp_lg}); else n_pass++;
      n_checks++; if ({fetch_valid, lpm_valid} !== {ev_f, ev_l}) $display("FAIL rand_valid[%0d]: got %b want %b", i, {fetch_valid, lpm_valid}, {ev_f, ev_l}); else n_pass++;
      if (ev_f) begin
        n_checks++; if (fetch_data !== q[0].fdata) $display("FAIL rand_fdata[%0d]: got %h want %h", i, fetch_data, q[0].fdata); else n_pass++;
      end
      if (ev_l) begin
        n_checks++; if (lpm_data !== q[0].ldata) $display("FAIL rand_ldata[%0d]: got %h want %h", i, lpm_data, q[0].ldata); else n_pass++;
      end
      f_busy = fetch_req && !exp_fg;
      l_busy = lpm_req && !exp_lg;
      @(posedge clk); #1;
    end
    idle(3);
  endtask

  // --------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    rom[5] = 16'hBB05;
    rom[9] = 16'hBB06;
    test_reset();
    test_single_fetch();
    test_lpm_bytes();
`ifdef PROG_MEM_FAIRNESS_EN
    test_collision_fair();
`else
    test_collision_strict();
`endif
    test_streaming();
    test_reset_midflight();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
